// File: rtl/bp_sat_counter_table.sv
// -----------------------------------------------------------------------------
// bp_sat_counter_table
//
// Bimodal branch predictor: a table of 2**IDX_W saturating counters, CTR_W bits
// each, indexed by fetch-PC bits. The fetch side issues lookups and receives a
// registered taken/not-taken prediction one cycle later, together with the
// table index that was used. Branch resolution in execute hands that index
// back with the actual outcome, and the selected counter moves one step toward
// that outcome, saturating at both ends. A saturating statistics counter
// counts mispredicted updates.
//
// Optional feature (compile-time macro BP_GSHARE_HIST_EN):
//   When defined, an IDX_W-bit global history register (GHR) of resolved
//   outcomes is XORed into the lookup index (gshare hashing). Update indices
//   are always used exactly as supplied. When undefined, no history logic
//   exists and the index is the PC bits alone.
//
// Parameters
//   PC_W       fetch/branch PC width
//   PC_LSB     lowest PC bit used for indexing (skips the byte offset)
//   IDX_W      index width; table depth is 2**IDX_W
//   CTR_W      counter width (>= 1); prediction is the counter MSB
//   RESET_CTR  counter value after reset (default: strongly taken)
//   CNT_W      mispredict statistics counter width
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous, active-high reset
//   en            enables table/history updates and statistics counting;
//                 lookups are served regardless
//   lookup_valid  lookup request this cycle
//   lookup_pc     PC of the branch being predicted
//   pred_valid    prediction valid, one cycle after lookup_valid
//   pred_taken    predicted direction, 1 = taken
//   pred_idx      table index used; returned later on upd_idx
//   upd_valid     resolved-branch update this cycle
//   upd_idx       index captured from pred_idx at prediction time
//   upd_taken     actual outcome, 1 = taken
//   upd_pred      direction that was predicted for this branch
//   cnt_clr       synchronous clear of mispred_cnt (wins over increment)
//   mispred_cnt   saturating count of mispredicted updates
// -----------------------------------------------------------------------------
module bp_sat_counter_table #(
  parameter int PC_W      = 32,
  parameter int PC_LSB    = 2,
  parameter int IDX_W     = 6,
  parameter int CTR_W     = 2,
  parameter int RESET_CTR = (1 << CTR_W) - 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int              DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(RESET_CTR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CTR_W-1:0] ctr_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Update side: a single port, so at most one counter changes per cycle.
  // ---------------------------------------------------------------------------
  logic             upd_fire;
  logic             mispredict;
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_next;

  assign upd_fire   = upd_valid & en;
  assign mispredict = upd_fire & (upd_pred ^ upd_taken);

  // Saturating step toward the resolved outcome; the explicit end checks
  // keep the counter from wrapping in either direction.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    upd_cur  = ctr_q[upd_idx];
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_W'(1);
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - CTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup index
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] lidx;

  assign pc_idx = lookup_pc[PC_LSB+IDX_W-1:PC_LSB];

`ifdef BP_GSHARE_HIST_EN
  // Global history of resolved outcomes, newest in bit 0. A lookup in the
  // same cycle as an update hashes with the pre-shift value because lidx is
  // taken from the register output.
  logic [IDX_W-1:0] ghr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (upd_fire) begin
      ghr_q <= IDX_W'({ghr_q, upd_taken});
    end
  end

  assign lidx = pc_idx ^ ghr_q;
`else
  assign lidx = pc_idx;
`endif

  // Only the index bits of lookup_pc matter; fold the rest into a sink so
  // the deliberate non-use is visible.
  logic unused_pc;
  assign unused_pc = ^lookup_pc;

  // ---------------------------------------------------------------------------
  // Write-to-read bypass: a lookup that hits the counter being updated this
  // cycle sees the post-update value, so the prediction is never one update
  // stale.
  // ---------------------------------------------------------------------------
  logic             bypass_hit;
  logic [CTR_W-1:0] lookup_ctr;

  assign bypass_hit = upd_fire && (upd_idx == lidx);
  assign lookup_ctr = bypass_hit ? upd_next : ctr_q[lidx];

  // ---------------------------------------------------------------------------
  // Counter table
  // ---------------------------------------------------------------------------
  // NOTE: the table is inside the asynchronous reset because every counter
  // must read RESET_CTR the moment reset asserts; this maps it to flops
  // rather than a RAM macro, which cannot be reset in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_fire) begin
      ctr_q[upd_idx] <= upd_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction register. Direction and index hold when no lookup arrives;
  // only the valid flag drops.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken <= lookup_ctr[CTR_W-1];
        pred_idx   <= lidx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mispredict statistics: clear wins over increment, holds at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt <= '0;
    end else if (cnt_clr) begin
      mispred_cnt <= '0;
    end else if (mispredict && (mispred_cnt != CNT_MAX)) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bp_sat_counter_table.sv
// -----------------------------------------------------------------------------
// tb_bp_sat_counter_table
//
// Directed bench for bp_sat_counter_table. A main instance with default
// parameters is driven from a table of single-cycle vectors with hand-computed
// results, followed by hand-written sequences for mid-stream reset. Two extra
// instances share the same inputs: one with CNT_W=2 (statistics saturation)
// and one with CTR_W=1 (last-outcome degenerate case). With BP_GSHARE_HIST_EN
// defined, a history-hashing sequence replaces the PC-only index checks.
// -----------------------------------------------------------------------------
module tb_bp_sat_counter_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;
  logic        cnt_clr;

  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic [15:0] mispred_cnt;

  logic        s_unused_valid;
  logic        s_unused_taken;
  logic [5:0]  s_unused_idx;
  logic [1:0]  s_mispred_cnt;

  logic        c_pred_valid;
  logic        c_pred_taken;
  logic [5:0]  c_unused_idx;
  logic [15:0] c_unused_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_sat_counter_table u_dut (
    .clk(clk), .rst(rst), .en(en),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .cnt_clr(cnt_clr), .mispred_cnt(mispred_cnt)
  );

  bp_sat_counter_table #(.CNT_W(2)) u_small_cnt (
    .clk(clk), .rst(rst), .en(en),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(s_unused_valid), .pred_taken(s_unused_taken), .pred_idx(s_unused_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .cnt_clr(cnt_clr), .mispred_cnt(s_mispred_cnt)
  );

  bp_sat_counter_table #(.CTR_W(1)) u_one_bit (
    .clk(clk), .rst(rst), .en(en),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(c_pred_valid), .pred_taken(c_pred_taken), .pred_idx(c_unused_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .cnt_clr(cnt_clr), .mispred_cnt(c_unused_cnt)
  );

  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic        uv;
    logic [5:0]  ui;
    logic        ut;
    logic        up;
    logic        en;
    logic        clr;
    logic        e_valid;
    logic        e_taken;
    logic [5:0]  e_idx;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic lv, input logic [31:0] pc, input logic uv,
                        input logic [5:0] ui, input logic ut, input logic up,
                        input logic e, input logic clr);
    lookup_valid = lv;
    lookup_pc    = pc;
    upd_valid    = uv;
    upd_idx      = ui;
    upd_taken    = ut;
    upd_pred     = up;
    en           = e;
    cnt_clr      = clr;
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic lv, input logic [31:0] pc, input logic uv,
                              input logic [5:0] ui, input logic ut, input logic up,
                              input logic e, input logic clr, input logic ev,
                              input logic et, input logic [5:0] ei, input logic [15:0] ec);
    vec_t v;
    v.lv = lv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut; v.up = up;
    v.en = e; v.clr = clr;
    v.e_valid = ev; v.e_taken = et; v.e_idx = ei; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // ---- reset state --------------------------------------------------------
    idle();
    tick();
    check("reset pred_valid", 32'(pred_valid), 32'd0);
    check("reset pred_taken", 32'(pred_taken), 32'd0);
    check("reset pred_idx", 32'(pred_idx), 32'd0);
    check("reset mispred_cnt", 32'(mispred_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post-reset no pred", 32'(pred_valid), 32'd0);

`ifndef BP_GSHARE_HIST_EN
    // ---- table-driven vectors ----------------------------------------------
    //             lv  pc            uv  ui  ut  up  en  clr | vld tkn idx cnt
    vecs.push_back(mk(1, 32'h40,       0, 0,  0, 0, 1, 0,   1, 1, 6'h10, 0)); // 0x40 -> idx 0x10, ctr 3
    vecs.push_back(mk(0, 32'h0,        1, 5,  0, 1, 1, 0,   0, 1, 6'h10, 1)); // ctr5 3->2
    vecs.push_back(mk(0, 32'h0,        1, 5,  0, 1, 1, 0,   0, 1, 6'h10, 2)); // 2->1
    vecs.push_back(mk(0, 32'h0,        1, 5,  0, 1, 1, 0,   0, 1, 6'h10, 3)); // 1->0
    vecs.push_back(mk(0, 32'h0,        1, 5,  0, 0, 1, 0,   0, 1, 6'h10, 3)); // 0 stays 0
    vecs.push_back(mk(1, 32'h14,       0, 0,  0, 0, 1, 0,   1, 0, 6'd5,  3)); // idx5 -> not taken
    vecs.push_back(mk(0, 32'h0,        1, 5,  1, 0, 1, 0,   0, 0, 6'd5,  4)); // 0->1
    vecs.push_back(mk(0, 32'h0,        1, 5,  1, 1, 1, 0,   0, 0, 6'd5,  4)); // 1->2
    vecs.push_back(mk(1, 32'h14,       0, 0,  0, 0, 1, 0,   1, 1, 6'd5,  4)); // idx5 -> taken
    vecs.push_back(mk(0, 32'h0,        1, 7,  0, 1, 1, 0,   0, 1, 6'd5,  5)); // ctr7 3->2
    vecs.push_back(mk(1, 32'h1C,       1, 7,  0, 0, 1, 0,   1, 0, 6'd7,  5)); // bypass: 2->1
    vecs.push_back(mk(1, 32'h1C,       1, 7,  1, 0, 1, 0,   1, 1, 6'd7,  6)); // bypass: 1->2
    vecs.push_back(mk(1, 32'h1C,       1, 7,  0, 1, 0, 0,   1, 1, 6'd7,  6)); // en=0: no change, no bypass
    vecs.push_back(mk(0, 32'h0,        1, 7,  0, 1, 0, 0,   0, 1, 6'd7,  6)); // en=0 again
    vecs.push_back(mk(1, 32'h1C,       0, 0,  0, 0, 1, 0,   1, 1, 6'd7,  6)); // ctr7 still 2
    vecs.push_back(mk(0, 32'h0,        1, 9,  1, 1, 1, 0,   0, 1, 6'd7,  6)); // ctr9 stays 3
    vecs.push_back(mk(1, 32'h24,       0, 0,  0, 0, 1, 0,   1, 1, 6'd9,  6)); // no wrap to 0
    vecs.push_back(mk(1, 32'hFFFFFF17, 0, 0,  0, 0, 1, 0,   1, 1, 6'd5,  6)); // upper/low PC bits ignored
    vecs.push_back(mk(1, 32'hFC,       1, 63, 0, 0, 1, 0,   1, 1, 6'd63, 6)); // top index, bypass 3->2
    vecs.push_back(mk(0, 32'h0,        0, 0,  0, 0, 1, 1,   0, 1, 6'd63, 0)); // clear
    vecs.push_back(mk(0, 32'h0,        1, 20, 1, 0, 1, 0,   0, 1, 6'd63, 1));
    vecs.push_back(mk(0, 32'h0,        1, 20, 1, 0, 1, 0,   0, 1, 6'd63, 2));
    vecs.push_back(mk(0, 32'h0,        1, 20, 1, 0, 1, 0,   0, 1, 6'd63, 3));
    vecs.push_back(mk(0, 32'h0,        1, 20, 1, 0, 1, 1,   0, 1, 6'd63, 0)); // clear beats increment
    vecs.push_back(mk(1, 32'h50,       0, 0,  0, 0, 1, 0,   1, 1, 6'd20, 0));
    vecs.push_back(mk(1, 32'h14,       1, 7,  0, 1, 1, 0,   1, 1, 6'd5,  1)); // no false bypass

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].lv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut,
             vecs[i].up, vecs[i].en, vecs[i].clr);
      tick();
      check($sformatf("v%0d pred_valid", i), 32'(pred_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_taken));
      check($sformatf("v%0d pred_idx", i), 32'(pred_idx), 32'(vecs[i].e_idx));
      check($sformatf("v%0d mispred_cnt", i), 32'(mispred_cnt), 32'(vecs[i].e_cnt));
    end

    // ---- mid-stream reset (ctr5=2, mispred_cnt=1) ---------------------------
    set_in(0, 32'h0, 1, 5, 0, 1, 1, 0); tick();   // 2->1, cnt 2
    set_in(0, 32'h0, 1, 5, 0, 1, 1, 0); tick();   // 1->0, cnt 3
    set_in(1, 32'h14, 0, 0, 0, 0, 1, 0); tick();
    check("pre-rst pred_taken idx5", 32'(pred_taken), 32'd0);
    check("pre-rst mispred_cnt", 32'(mispred_cnt), 32'd3);
    set_in(1, 32'h1C, 1, 7, 0, 1, 1, 0);          // in flight when reset hits
    #2;
    rst = 1'b1;
    #1;
    check("async rst pred_valid", 32'(pred_valid), 32'd0);
    check("async rst pred_idx", 32'(pred_idx), 32'd0);
    check("async rst mispred_cnt", 32'(mispred_cnt), 32'd0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    check("rst release no pred", 32'(pred_valid), 32'd0);
    set_in(1, 32'h14, 0, 0, 0, 0, 1, 0); tick();
    check("post-rst idx5 restored", 32'(pred_taken), 32'd1);
    check("post-rst pred_valid", 32'(pred_valid), 32'd1);

    // ---- CNT_W=2 saturation and CTR_W=1 degenerate table --------------------
    do_reset();
    set_in(0, 32'h0, 1, 5, 0, 1, 1, 0); tick();
    check("small cnt 1", 32'(s_mispred_cnt), 32'd1);
    set_in(0, 32'h0, 1, 5, 0, 1, 1, 0); tick();
    check("small cnt 2", 32'(s_mispred_cnt), 32'd2);
    set_in(1, 32'h14, 0, 0, 0, 0, 1, 0); tick();
    check("1-bit no wrap below 0", 32'(c_pred_taken), 32'd0);
    check("1-bit pred_valid", 32'(c_pred_valid), 32'd1);
    set_in(0, 32'h0, 1, 5, 1, 0, 1, 0); tick();
    check("small cnt 3", 32'(s_mispred_cnt), 32'd3);
    set_in(0, 32'h0, 1, 5, 1, 0, 1, 0); tick();
    check("small cnt hold 4th", 32'(s_mispred_cnt), 32'd3);
    set_in(1, 32'h14, 1, 5, 1, 0, 1, 0); tick();
    check("small cnt hold 5th", 32'(s_mispred_cnt), 32'd3);
    check("wide cnt 5", 32'(mispred_cnt), 32'd5);
    check("1-bit bypass at max", 32'(c_pred_taken), 32'd1);
    set_in(1, 32'h14, 0, 0, 0, 0, 1, 0); tick();
    check("1-bit no wrap above max", 32'(c_pred_taken), 32'd1);
`else
    // ---- gshare history hashing ---------------------------------------------
    set_in(1, 32'h40, 0, 0, 0, 0, 1, 0); tick();
    check("gs ghr0 pred_idx", 32'(pred_idx), 32'h10);
    set_in(0, 32'h0, 1, 3, 1, 1, 1, 0); tick();   // ghr=01
    set_in(0, 32'h0, 1, 3, 1, 1, 1, 0); tick();   // ghr=11
    set_in(1, 32'h40, 0, 0, 0, 0, 1, 0); tick();
    check("gs ghr3 pred_idx", 32'(pred_idx), 32'h13);
    set_in(1, 32'h40, 1, 3, 0, 1, 0, 0); tick();  // en=0: ghr frozen
    check("gs en0 pred_idx", 32'(pred_idx), 32'h13);
    set_in(1, 32'h40, 0, 0, 0, 0, 1, 0); tick();
    check("gs en0 ghr kept", 32'(pred_idx), 32'h13);
    check("gs en0 no count", 32'(mispred_cnt), 32'd0);
    set_in(0, 32'h0, 1, 3, 0, 1, 1, 0); tick();   // ghr=110
    set_in(1, 32'h40, 1, 6'h16, 1, 1, 1, 0); tick(); // pre-shift ghr, then ghr=1101
    check("gs pre-shift pred_idx", 32'(pred_idx), 32'h16);
    set_in(1, 32'h40, 0, 0, 0, 0, 1, 0); tick();
    check("gs ghr13 pred_idx", 32'(pred_idx), 32'h1D);
    check("gs mispred_cnt", 32'(mispred_cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
